btn_debounce_edge: RTL

//  Conditions a raw, asynchronous, bouncing push-button/switch level into a clean stable level plus

---
 rtl/debounce_pkg.sv | 14 +
 rtl/btn_debounce_edge_if.sv | 23 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/btn_debounce_edge.sv | 116 +++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state encoding and defaults for the button debouncer
package debounce_pkg;

    typedef enum logic [1:0] {
        S_LOW      = 2'd0,
        S_CHK_HIGH = 2'd1,
        S_HIGH     = 2'd2,
        S_CHK_LOW  = 2'd3
    } db_state_t;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
    localparam int DEFAULT_PRESS_W         = 8;

endpackage

// File: rtl/btn_debounce_edge_if.sv
// rtl/btn_debounce_edge_if.sv - button input/control and conditioned outputs bundle
interface btn_debounce_edge_if #(
    parameter int PRESS_W = 8
);
    logic               btn_raw;
    logic               enable;
    logic               clear_count;
    logic               level;
    logic               rise_pulse;
    logic               fall_pulse;
    logic [PRESS_W-1:0] press_count;
    logic               busy;

    modport master (
        output btn_raw, enable, clear_count,
        input  level, rise_pulse, fall_pulse, press_count, busy
    );

    modport slave (
        input  btn_raw, enable, clear_count,
        output level, rise_pulse, fall_pulse, press_count, busy
    );
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for asynchronous single-bit inputs
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic s1;
    logic s2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end

    assign q = s2;
endmodule

// File: rtl/btn_debounce_edge.sv
// rtl/btn_debounce_edge.sv - debounced button level, edge pulses and saturating press counter
module btn_debounce_edge
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int PRESS_W         = DEFAULT_PRESS_W
) (
    input logic           clk,
    input logic           rst_n,
    btn_debounce_edge_if.slave bus
);
    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    db_state_t          state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               rise_nxt, fall_nxt;
    logic               btn_sync;
    logic               level_q, busy_q, rise_q, fall_q;
    logic [PRESS_W-1:0] press_q;

    sync_2ff u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.btn_raw),
        .q     (btn_sync)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_LOW;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A check state aborts back to the stable state it came from whenever the
    // synchronized input reverts or debouncing is disabled.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            S_LOW: begin
                if (btn_sync && bus.enable) begin
                    state_nxt = S_CHK_HIGH;
                    cnt_nxt   = '0;
                end
            end
            S_CHK_HIGH: begin
                if (!btn_sync || !bus.enable) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_HIGH: begin
                if (!btn_sync && bus.enable) begin
                    state_nxt = S_CHK_LOW;
                    cnt_nxt   = '0;
                end
            end
            S_CHK_LOW: begin
                if (btn_sync || !bus.enable) begin
                    state_nxt = S_HIGH;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = S_LOW;
                    cnt_nxt   = '0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = S_LOW;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            busy_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= '0;
        end else begin
            level_q <= (state_nxt == S_HIGH) || (state_nxt == S_CHK_LOW);
            busy_q  <= (state_nxt == S_CHK_HIGH) || (state_nxt == S_CHK_LOW);
            rise_q  <= rise_nxt;
            fall_q  <= fall_nxt;
            if (bus.clear_count) begin
                press_q <= '0;
            end else if (rise_nxt && (press_q != {PRESS_W{1'b1}})) begin
                press_q <= press_q + 1'b1;
            end
        end
    end

    assign bus.level       = level_q;
    assign bus.busy        = busy_q;
    assign bus.rise_pulse  = rise_q;
    assign bus.fall_pulse  = fall_q;
    assign bus.press_count = press_q;
endmodule
